rom_download_packer: RTL and testbench
======================================

// Module: rom_download_packer
// PURPOSE
//   Downstream of the SPI file-download stage. Takes its byte-wide write strobes (wr/a/d) and packs
//   even/odd byte pairs into 16-bit big-endian words. Buffers them in a small FIFO.
//   Issues req/ack word writes to the SDRAM controller's ROM-load port.
//   Tracks loaded ROM size and signals completion once all buffered data is committed.
// PARAMETERS
//   ADDR_W      25  byte address width of the download stream
//   FIFO_DEPTH  4   word FIFO entries; power of two, >= 2
//   BYTE_SWAP   0   1: even byte goes to bits [7:0] instead of [15:8]
// PORTS
//   clk          in   1         core clock, same domain as the download stage's write strobe
//   reset_n      in   1         asynchronous, active-low reset
//   dl_active    in   1         download in progress (the download stage's downloading output)
//   dl_wr        in   1         one-cycle byte write strobe
//   dl_addr      in   ADDR_W    byte address of dl_data
//   dl_data      in   8         byte to write
//   mem_req      out  1         word write request to SDRAM port
//   mem_addr     out  ADDR_W-1  word address (byte address >> 1)
//   mem_din      out  16        word data
//   mem_be       out  2         byte enables, [1]=bits 15:8, [0]=bits 7:0
//   mem_ack      in   1         one-cycle acknowledge; completes the current request
//   rom_size     out  ADDR_W    highest written byte address + 1
//   dl_done      out  1         one-cycle pulse when the download finishes and the FIFO drains
//   overflow     out  1         sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
//   Reset values: mem_req=0, mem_addr=0, mem_din=0, mem_be=0, rom_size=0, dl_done=0, overflow=0.
//   Reset also clears the pending byte and empties the FIFO. Reset mid-request drops the request without any ack.
//   Packer: holds at most one pending even byte (data, word address, valid).
//   - Even-address byte, nothing pending: store it as pending. No FIFO push.
//   - Even-address byte, pending valid: push the pending byte as a half word (be=2'b10, or 2'b01 if BYTE_SWAP).
//     The new byte then becomes pending. Both events happen in the same cycle.
//   - Odd-address byte, pending for the same word: push the full word, be=2'b11, and clear pending.
//   - Odd-address byte, no matching pending: flush any pending byte as a half word, then push the odd byte as a half word.
//     When two pushes are needed in one cycle, the pending flush goes in this cycle.
//     The odd byte goes in the next cycle from a 1-entry skid register. dl_wr never arrives closer than 2 cycles apart.
//   - dl_active falling edge with pending valid: push the pending byte as a half word.
//   Word data: even byte in [15:8] and odd byte in [7:0] (swapped if BYTE_SWAP=1). Disabled half is 8'h00.
//   FIFO: push when not full. On push while full, drop the word and set overflow, which stays set until reset.
//     A simultaneous push and pop when full is accepted (pop frees the slot first).
//     Pointers are log2(FIFO_DEPTH)+1 bits with wrap bit. Full = pointers equal except the MSB. Empty = pointers equal.
//   Memory handshake FSM, states IDLE -> REQ -> IDLE:
//   - IDLE: if FIFO not empty, load mem_addr/mem_din/mem_be from the FIFO head, pop it, set mem_req=1, go to REQ.
//   - REQ: mem_req and its outputs hold stable until mem_ack=1. On ack, deassert mem_req and return to IDLE.
//     The minimum gap between requests is one cycle.
//   - mem_ack while in IDLE is ignored.
//   rom_size: on every accepted dl_wr, rom_size = max(rom_size, dl_addr+1). Computed ADDR_W+1 wide and saturated at all-ones.
//     Cleared when dl_active rises.
//   dl_done: pulses one cycle after dl_active is low, pending is empty, the skid register is empty, the FIFO is empty,
//     and the FSM is IDLE, for the first such cycle after a dl_active falling edge. At most one pulse per download.
//   dl_wr while dl_active=0 is still packed (the strobe is authoritative). This does not retrigger dl_done.
// STRUCTURE
//   Shared package rom_dl_pkg: FSM state enum {IDLE, REQ}, BE_FULL/BE_HI/BE_LO constants,
//     FIFO entry record {word_addr, data[15:0], be[1:0]}.
//   One natural sub-module: rom_dl_fifo, a synchronous FIFO parameterised by width and depth.
//     It has push/pop/full/empty and an async active-low reset.
//   The packer, skid register, FSM and size tracking stay in the top level.
// TESTING
//   1. Sequential bytes 00..05 = AA,BB,CC,DD,EE,FF at addr 0..5, ack 2 cycles after each req
//      -> words (0,AABB,11), (1,CCDD,11), (2,EEFF,11); rom_size=6; one dl_done after drain.
//   2. Odd length: bytes 12,34,56 at addr 0..2, then dl_active falls
//      -> (0,1234,11), (1,5600,10); dl_done only after the second ack.
//   3. Out of order: addr 5=77, then addr 8=88, then dl_active falls
//      -> (2,0077,01), (4,8800,10); rom_size=9.
//   4. Backpressure: 12 sequential bytes with mem_ack held low
//      -> FIFO fills (4 words + 1 in REQ), next word dropped, overflow=1 and stays set; acks resume correct order.
//   5. reset_n asserted during REQ with 2 words queued -> all outputs 0 immediately; after release no req without new input.
//   6. BYTE_SWAP=1, bytes 12,34 at addr 0 -> (0,3412,11); single byte at addr 2=56 flushed -> (1,0056,01).

Source files
------------

// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download packer: FSM states, byte-enable codes, FIFO entry record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rom_dl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   localparam logic [1:0] BE_FULL = 2'b11;
   localparam logic [1:0] BE_HI   = 2'b10;
   localparam logic [1:0] BE_LO   = 2'b01;

   // Word address field is sized for the widest supported byte address (32 bits);
   // narrower instances zero-extend on push and truncate on pop.
   localparam int WADDR_MAX_W = 31;

   typedef struct packed {
      logic [WADDR_MAX_W-1:0] word_addr;
      logic [15:0]            data;
      logic [1:0]             be;
   } fifo_entry_t;

endpackage

// File: rtl/rom_download_packer_if.sv
// Word-write port between the packer (master) and the SDRAM controller ROM-load port (slave).
// Latency: n/a (wires only).
// Backpressure: request holds until the slave returns a one-cycle ack.
interface rom_download_packer_if #(
   parameter int ADDR_W = 25
) ();

   logic              mem_req;
   logic [ADDR_W-2:0] mem_addr;
   logic [15:0]       mem_din;
   logic [1:0]        mem_be;
   logic              mem_ack;

   modport master (
      output mem_req,
      output mem_addr,
      output mem_din,
      output mem_be,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      input  mem_din,
      input  mem_be,
      output mem_ack
   );

endinterface

// File: rtl/rom_dl_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is presented combinationally.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module rom_dl_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head_dat,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_empty    = (r_wr_ptr == r_rd_ptr);
   assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop_ok   = i_pop && !o_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign w_push_ok  = i_push && (!o_full || w_pop_ok);
   assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

   // Pointer advance on accepted push/pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
   end

endmodule

// File: rtl/rom_download_packer.sv
// Packs download byte strobes into 16-bit words, queues them and writes them to the SDRAM ROM port.
// Latency: a completed word reaches mem_req two cycles after its last byte strobe (FIFO + FSM load).
// Backpressure: mem_req holds until mem_ack; words arriving with the FIFO full are dropped and flagged.
module rom_download_packer
   import rom_dl_pkg::*;
#(
   parameter int ADDR_W     = 25,
   parameter int FIFO_DEPTH = 4,
   parameter int BYTE_SWAP  = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  dl_active,
   input  logic                  dl_wr,
   input  logic [ADDR_W-1:0]     dl_addr,
   input  logic [7:0]            dl_data,
   rom_download_packer_if.master mem,
   output logic [ADDR_W-1:0]     rom_size,
   output logic                  dl_done,
   output logic                  overflow
);

   localparam logic [1:0] BE_EVEN = (BYTE_SWAP != 0) ? BE_LO : BE_HI;
   localparam logic [1:0] BE_ODD  = (BYTE_SWAP != 0) ? BE_HI : BE_LO;

   // Place the even/odd bytes in their lanes for the configured byte order.
   function automatic logic [15:0] f_word(input logic [7:0] even_b, input logic [7:0] odd_b);
      return (BYTE_SWAP != 0) ? {odd_b, even_b} : {even_b, odd_b};
   endfunction

   function automatic fifo_entry_t f_entry(input logic [ADDR_W-2:0] waddr,
                                           input logic [15:0] data, input logic [1:0] be);
      fifo_entry_t e;
      e.word_addr = WADDR_MAX_W'(waddr);
      e.data      = data;
      e.be        = be;
      return e;
   endfunction

   logic              w_even;
   logic [ADDR_W-2:0] w_waddr;
   logic              r_act_d;
   logic              w_rise;
   logic              w_fall;
   logic              r_pend_vld;
   logic [7:0]        r_pend_dat;
   logic [ADDR_W-2:0] r_pend_waddr;
   logic              r_skid_vld;
   logic [7:0]        r_skid_dat;
   logic [ADDR_W-2:0] r_skid_waddr;
   logic              w_to_skid;
   logic              w_push;
   fifo_entry_t       w_push_ent;
   fifo_entry_t       w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   state_t            r_state;
   logic [ADDR_W:0]   w_size_sum;
   logic [ADDR_W-1:0] w_size_new;
   logic              r_done_armed;
   logic              w_armed;
   logic              w_all_idle;
   logic              w_unused_addr_hi;

   assign w_even     = ~dl_addr[0];
   assign w_waddr    = dl_addr[ADDR_W-1:1];
   assign w_rise     = dl_active && !r_act_d;
   assign w_fall     = !dl_active && r_act_d;
   // Odd byte that cannot join the pending byte: pending goes now, odd byte next cycle.
   assign w_to_skid  = dl_wr && !w_even && r_pend_vld && (r_pend_waddr != w_waddr);
   assign w_pop      = (r_state == IDLE) && !w_empty;
   assign w_size_sum = {1'b0, dl_addr} + {{ADDR_W{1'b0}}, 1'b1};
   assign w_size_new = w_size_sum[ADDR_W] ? {ADDR_W{1'b1}} : w_size_sum[ADDR_W-1:0];
   assign w_armed    = r_done_armed || w_fall;
   assign w_all_idle = !dl_active && !dl_wr && !r_pend_vld && !r_skid_vld &&
                       w_empty && (r_state == IDLE);
   assign w_unused_addr_hi = ^w_head.word_addr[WADDR_MAX_W-1:ADDR_W-1];

   // Select the single word pushed this cycle; the skid entry has priority.
   always_comb begin
      w_push     = 1'b0;
      w_push_ent = '0;
      if (r_skid_vld) begin
         w_push     = 1'b1;
         w_push_ent = f_entry(r_skid_waddr, f_word(8'h00, r_skid_dat), BE_ODD);
      end else if (dl_wr) begin
         if (!w_even && r_pend_vld && (r_pend_waddr == w_waddr)) begin
            w_push     = 1'b1;
            w_push_ent = f_entry(w_waddr, f_word(r_pend_dat, dl_data), BE_FULL);
         end else if (r_pend_vld) begin
            w_push     = 1'b1;
            w_push_ent = f_entry(r_pend_waddr, f_word(r_pend_dat, 8'h00), BE_EVEN);
         end else if (!w_even) begin
            w_push     = 1'b1;
            w_push_ent = f_entry(w_waddr, f_word(8'h00, dl_data), BE_ODD);
         end
      end else if (w_fall && r_pend_vld) begin
         w_push     = 1'b1;
         w_push_ent = f_entry(r_pend_waddr, f_word(r_pend_dat, 8'h00), BE_EVEN);
      end
   end

   // Pending even byte and odd-byte skid register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend_vld   <= 1'b0;
         r_pend_dat   <= '0;
         r_pend_waddr <= '0;
         r_skid_vld   <= 1'b0;
         r_skid_dat   <= '0;
         r_skid_waddr <= '0;
      end else begin
         r_skid_vld <= w_to_skid;
         if (w_to_skid) begin
            r_skid_dat   <= dl_data;
            r_skid_waddr <= w_waddr;
         end
         if (dl_wr) begin
            r_pend_vld <= w_even;
            if (w_even) begin
               r_pend_dat   <= dl_data;
               r_pend_waddr <= w_waddr;
            end
         end else if (w_fall) begin
            r_pend_vld <= 1'b0;
         end
      end
   end

   rom_dl_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_push     (w_push),
      .i_push_dat (w_push_ent),
      .i_pop      (w_pop),
      .o_head_dat (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   // Sticky drop flag: a push that the FIFO could not accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          overflow <= 1'b0;
      else if (w_push && w_full && !w_pop)   overflow <= 1'b1;
   end

   // Memory handshake FSM: load head into the request registers, hold until ack.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         mem.mem_req  <= 1'b0;
         mem.mem_addr <= '0;
         mem.mem_din  <= '0;
         mem.mem_be   <= '0;
      end else begin
         case (r_state)
            IDLE: if (!w_empty) begin
               mem.mem_addr <= w_head.word_addr[ADDR_W-2:0];
               mem.mem_din  <= w_head.data;
               mem.mem_be   <= w_head.be;
               mem.mem_req  <= 1'b1;
               r_state      <= REQ;
            end
            REQ: if (mem.mem_ack) begin
               mem.mem_req <= 1'b0;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // ROM size tracking and one-shot completion pulse per download.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_act_d      <= 1'b0;
         rom_size     <= '0;
         dl_done      <= 1'b0;
         r_done_armed <= 1'b0;
      end else begin
         r_act_d <= dl_active;
         if (dl_wr) begin
            if (w_rise || (w_size_new > rom_size)) rom_size <= w_size_new;
         end else if (w_rise) begin
            rom_size <= '0;
         end
         dl_done      <= w_armed && w_all_idle;
         r_done_armed <= w_armed && !w_all_idle && !w_rise;
      end
   end

endmodule

// File: tb/tb_rom_download_packer.sv
// Directed bench for rom_download_packer: packing, FIFO overflow, handshake, reset and byte swap.
// Latency: n/a.
// Backpressure: the bench acks requests two cycles after they rise when acks are enabled.
module tb_rom_download_packer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        dl_active, dl_wr;
   logic [24:0] dl_addr;
   logic [7:0]  dl_data;
   logic [24:0] rom_size;
   logic        dl_done, overflow;

   logic        dl_active_1, dl_wr_1;
   logic [24:0] dl_addr_1;
   logic [7:0]  dl_data_1;
   logic [24:0] rom_size_1;
   logic        dl_done_1, overflow_1;

   rom_download_packer_if #(.ADDR_W(25)) mif ();
   rom_download_packer_if #(.ADDR_W(25)) mif1 ();

   rom_download_packer #(.ADDR_W(25), .FIFO_DEPTH(4), .BYTE_SWAP(0)) dut (
      .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
      .dl_addr(dl_addr), .dl_data(dl_data), .mem(mif.master),
      .rom_size(rom_size), .dl_done(dl_done), .overflow(overflow));

   rom_download_packer #(.ADDR_W(25), .FIFO_DEPTH(4), .BYTE_SWAP(1)) dut_swap (
      .clk(clk), .reset_n(reset_n), .dl_active(dl_active_1), .dl_wr(dl_wr_1),
      .dl_addr(dl_addr_1), .dl_data(dl_data_1), .mem(mif1.master),
      .rom_size(rom_size_1), .dl_done(dl_done_1), .overflow(overflow_1));

   int          tests = 0;
   int          fails = 0;
   logic [41:0] wq[$];
   logic        prev_req;
   int          done_cnt;
   bit          ack_en = 1'b1;
   int          ack_cnt;

   // Request monitor: log {word_addr, data, be} on each rising mem_req; count dl_done pulses.
   initial begin
      prev_req = 1'b0;
      done_cnt = 0;
      forever begin
         @(negedge clk);
         if (mif.mem_req && !prev_req) wq.push_back({mif.mem_addr, mif.mem_din, mif.mem_be});
         prev_req = mif.mem_req;
         if (dl_done) done_cnt++;
      end
   end

   // Memory responder: one-cycle ack two cycles after a request rises.
   initial begin
      mif.mem_ack = 1'b0;
      ack_cnt     = 0;
      forever begin
         @(negedge clk);
         if (mif.mem_ack) mif.mem_ack = 1'b0;
         else if (ack_en && mif.mem_req) begin
            ack_cnt++;
            if (ack_cnt >= 2) begin
               mif.mem_ack = 1'b1;
               ack_cnt     = 0;
            end
         end else ack_cnt = 0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
      dl_addr = a; dl_data = d; dl_wr = 1'b1;
      tick(1);
      dl_wr = 1'b0;
      tick(1);
   endtask

   task automatic wr_byte_1(input logic [24:0] a, input logic [7:0] d);
      dl_addr_1 = a; dl_data_1 = d; dl_wr_1 = 1'b1;
      tick(1);
      dl_wr_1 = 1'b0;
      tick(1);
   endtask

   task automatic wait_words(input int n, input int budget);
      int c = 0;
      while (wq.size() < n && c < budget) begin tick(1); c++; end
   endtask

   task automatic wait_done(input int base, input int budget);
      int c = 0;
      while (done_cnt == base && c < budget) begin tick(1); c++; end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick(3);
      tests++;
      if ({mif.mem_req, mif.mem_addr, mif.mem_din, mif.mem_be} !== 43'd0) begin
         fails++; $display("FAIL reset_mem: got %h expected 0", {mif.mem_req, mif.mem_addr, mif.mem_din, mif.mem_be});
      end
      tests++;
      if ({rom_size, dl_done, overflow} !== 27'd0) begin
         fails++; $display("FAIL reset_status: got %h expected 0", {rom_size, dl_done, overflow});
      end
      reset_n = 1'b1;
      tick(2);
   endtask

   task automatic test_sequential();
      logic [7:0]  b[6]   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
      logic [41:0] ex[3]  = '{{24'd0, 16'hAABB, 2'b11}, {24'd1, 16'hCCDD, 2'b11}, {24'd2, 16'hEEFF, 2'b11}};
      logic [41:0] got;
      int          base;
      wq.delete(); base = done_cnt;
      dl_active = 1'b1; tick(2);
      for (int i = 0; i < 6; i++) wr_byte(25'(i), b[i]);
      dl_active = 1'b0;
      wait_words(3, 200);
      wait_done(base, 100);
      tick(5);
      tests++;
      if (wq.size() != 3) begin fails++; $display("FAIL seq_count: got %0d expected 3", wq.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < wq.size()) ? wq[i] : 'x;
         tests++;
         if (got !== ex[i]) begin fails++; $display("FAIL seq_word%0d: got %h expected %h", i, got, ex[i]); end
      end
      tests++;
      if (rom_size !== 25'd6) begin fails++; $display("FAIL seq_rom_size: got %0d expected 6", rom_size); end
      tests++;
      if (done_cnt - base != 1) begin fails++; $display("FAIL seq_done: got %0d pulses expected 1", done_cnt - base); end
   endtask

   task automatic test_odd_length();
      logic [41:0] ex[2] = '{{24'd0, 16'h1234, 2'b11}, {24'd1, 16'h5600, 2'b10}};
      logic [41:0] got;
      int          base;
      wq.delete(); base = done_cnt;
      dl_active = 1'b1; tick(2);
      wr_byte(25'd0, 8'h12); wr_byte(25'd1, 8'h34); wr_byte(25'd2, 8'h56);
      dl_active = 1'b0;
      wait_words(2, 200);
      tests++;
      if (done_cnt != base) begin fails++; $display("FAIL odd_early_done: got %0d pulses expected 0", done_cnt - base); end
      wait_done(base, 100);
      tick(5);
      for (int i = 0; i < 2; i++) begin
         got = (i < wq.size()) ? wq[i] : 'x;
         tests++;
         if (got !== ex[i]) begin fails++; $display("FAIL odd_word%0d: got %h expected %h", i, got, ex[i]); end
      end
      tests++;
      if (done_cnt - base != 1) begin fails++; $display("FAIL odd_done: got %0d pulses expected 1", done_cnt - base); end
   endtask

   task automatic test_out_of_order();
      logic [41:0] ex[2] = '{{24'd2, 16'h0077, 2'b01}, {24'd4, 16'h8800, 2'b10}};
      logic [41:0] got;
      int          base;
      wq.delete(); base = done_cnt;
      dl_active = 1'b1; tick(2);
      wr_byte(25'd5, 8'h77); wr_byte(25'd8, 8'h88);
      dl_active = 1'b0;
      wait_words(2, 200);
      wait_done(base, 100);
      tick(5);
      for (int i = 0; i < 2; i++) begin
         got = (i < wq.size()) ? wq[i] : 'x;
         tests++;
         if (got !== ex[i]) begin fails++; $display("FAIL ooo_word%0d: got %h expected %h", i, got, ex[i]); end
      end
      tests++;
      if (rom_size !== 25'd9) begin fails++; $display("FAIL ooo_rom_size: got %0d expected 9", rom_size); end
   endtask

   task automatic test_skid();
      logic [41:0] ex[2] = '{{24'd0, 16'hA100, 2'b10}, {24'd1, 16'h00B3, 2'b01}};
      logic [41:0] got;
      int          base;
      wq.delete(); base = done_cnt;
      dl_active = 1'b1; tick(2);
      wr_byte(25'd0, 8'hA1); wr_byte(25'd3, 8'hB3);
      dl_active = 1'b0;
      wait_words(2, 200);
      wait_done(base, 100);
      tick(5);
      for (int i = 0; i < 2; i++) begin
         got = (i < wq.size()) ? wq[i] : 'x;
         tests++;
         if (got !== ex[i]) begin fails++; $display("FAIL skid_word%0d: got %h expected %h", i, got, ex[i]); end
      end
      tests++;
      if (rom_size !== 25'd4) begin fails++; $display("FAIL skid_rom_size: got %0d expected 4", rom_size); end
      tests++;
      if (done_cnt - base != 1) begin fails++; $display("FAIL skid_done: got %0d pulses expected 1", done_cnt - base); end
   endtask

   task automatic test_idle_write_saturate();
      logic [41:0] got;
      int          base;
      wq.delete(); base = done_cnt;
      wr_byte(25'h1FFFFFF, 8'h5A);
      wait_words(1, 100);
      tick(10);
      got = (wq.size() > 0) ? wq[0] : 'x;
      tests++;
      if (got !== {24'hFFFFFF, 16'h005A, 2'b01}) begin
         fails++; $display("FAIL idle_word: got %h expected %h", got, {24'hFFFFFF, 16'h005A, 2'b01});
      end
      tests++;
      if (rom_size !== 25'h1FFFFFF) begin fails++; $display("FAIL sat_rom_size: got %h expected 1ffffff", rom_size); end
      tests++;
      if (done_cnt != base) begin fails++; $display("FAIL idle_no_done: got %0d pulses expected 0", done_cnt - base); end
   endtask

   task automatic test_backpressure();
      logic [41:0] got, ex;
      wq.delete();
      ack_en = 1'b0;
      dl_active = 1'b1; tick(2);
      for (int i = 0; i < 12; i++) wr_byte(25'(i), 8'(8'h10 + i));
      tick(2);
      tests++;
      if (overflow !== 1'b1) begin fails++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
      tests++;
      if (wq.size() != 1 || mif.mem_req !== 1'b1) begin
         fails++; $display("FAIL bp_stall: got %0d reqs req=%b expected 1 req=1", wq.size(), mif.mem_req);
      end
      dl_active = 1'b0;
      ack_en = 1'b1;
      wait_words(5, 300);
      tick(20);
      tests++;
      if (wq.size() != 5) begin fails++; $display("FAIL bp_count: got %0d expected 5", wq.size()); end
      for (int i = 0; i < 5; i++) begin
         ex  = {24'(i), 8'(8'h10 + 2*i), 8'(8'h11 + 2*i), 2'b11};
         got = (i < wq.size()) ? wq[i] : 'x;
         tests++;
         if (got !== ex) begin fails++; $display("FAIL bp_word%0d: got %h expected %h", i, got, ex); end
      end
      tests++;
      if (overflow !== 1'b1) begin fails++; $display("FAIL bp_sticky: got %b expected 1", overflow); end
   endtask

   task automatic test_reset_mid_req();
      int n0;
      wq.delete();
      ack_en = 1'b0;
      dl_active = 1'b1; tick(2);
      for (int i = 0; i < 6; i++) wr_byte(25'(i), 8'(8'h21 + i));
      tick(2);
      tests++;
      if (mif.mem_req !== 1'b1) begin fails++; $display("FAIL rst_pre_req: got %b expected 1", mif.mem_req); end
      reset_n = 1'b0;
      #1;
      tests++;
      if ({mif.mem_req, mif.mem_addr, mif.mem_din, mif.mem_be} !== 43'd0) begin
         fails++; $display("FAIL rst_async_mem: got %h expected 0", {mif.mem_req, mif.mem_addr, mif.mem_din, mif.mem_be});
      end
      tests++;
      if ({rom_size, dl_done, overflow} !== 27'd0) begin
         fails++; $display("FAIL rst_async_status: got %h expected 0", {rom_size, dl_done, overflow});
      end
      dl_active = 1'b0;
      tick(2);
      reset_n = 1'b1;
      n0 = wq.size();
      tick(15);
      tests++;
      if (mif.mem_req !== 1'b0 || wq.size() != n0) begin
         fails++; $display("FAIL rst_no_req: got req=%b new=%0d expected req=0 new=0", mif.mem_req, wq.size() - n0);
      end
      ack_en = 1'b1;
   endtask

   task automatic test_byte_swap();
      int c;
      dl_active_1 = 1'b1; tick(2);
      wr_byte_1(25'd0, 8'h12); wr_byte_1(25'd1, 8'h34); wr_byte_1(25'd2, 8'h56);
      dl_active_1 = 1'b0;
      c = 0;
      while (!mif1.mem_req && c < 50) begin tick(1); c++; end
      tests++;
      if ({mif1.mem_req, mif1.mem_addr, mif1.mem_din, mif1.mem_be} !== {1'b1, 24'd0, 16'h3412, 2'b11}) begin
         fails++; $display("FAIL swap_word0: got %h expected %h",
                           {mif1.mem_req, mif1.mem_addr, mif1.mem_din, mif1.mem_be}, {1'b1, 24'd0, 16'h3412, 2'b11});
      end
      mif1.mem_ack = 1'b1; tick(1); mif1.mem_ack = 1'b0; tick(1);
      c = 0;
      while (!mif1.mem_req && c < 50) begin tick(1); c++; end
      tests++;
      if ({mif1.mem_req, mif1.mem_addr, mif1.mem_din, mif1.mem_be} !== {1'b1, 24'd1, 16'h0056, 2'b01}) begin
         fails++; $display("FAIL swap_word1: got %h expected %h",
                           {mif1.mem_req, mif1.mem_addr, mif1.mem_din, mif1.mem_be}, {1'b1, 24'd1, 16'h0056, 2'b01});
      end
      mif1.mem_ack = 1'b1; tick(1); mif1.mem_ack = 1'b0; tick(1);
      tests++;
      if (rom_size_1 !== 25'd3) begin fails++; $display("FAIL swap_rom_size: got %0d expected 3", rom_size_1); end
   endtask

   initial begin
      reset_n = 1'b0;
      dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
      dl_active_1 = 1'b0; dl_wr_1 = 1'b0; dl_addr_1 = '0; dl_data_1 = '0;
      mif1.mem_ack = 1'b0;
      test_reset();
      test_sequential();
      test_odd_length();
      test_out_of_order();
      test_skid();
      test_idle_write_saturate();
      test_backpressure();
      test_reset_mid_req();
      test_byte_swap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
